// File: rtl/serial_bit_tx_if.sv
// Parallel-word handshake into serial_bit_tx: producer drives data/valid,
// transmitter answers with ready.
interface serial_bit_tx_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_bit_tx.sv
// Bit-serial line driver: start(1), DATA_W bits MSB-first, stop(0),
// each bit held CLKS_PER_BIT cycles; line idles low.
module serial_bit_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  serial_bit_tx_if.slave  tx,
  output logic            tx_line,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BIT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                line_d, busy_d, done_d;
  logic                bit_end;

  assign bit_end     = (cnt_q == CNT_LAST);
  assign tx.tx_ready = (state_q == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_line <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_line <= line_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        if (tx.tx_valid) begin
          shreg_d = tx.tx_data;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q << 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next-state values so the registered line
  // shows the start bit in the very first cycle after the accept edge.
  always_comb begin
    line_d = 1'b0;
    unique case (state_d)
      START:   line_d = 1'b1;
      DATA:    line_d = shreg_d[DATA_W-1];
      default: line_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

endmodule

// File: doc/serial_bit_tx.md
Name: serial_bit_tx

Overview:
- Single-line bit-serial transmitter. It is the driving end of the one-bit test/status line that the core's registered input samplers capture.
- Accepts a parallel word over a valid/ready handshake and frames it as start bit, DATA_W data bits MSB-first, then stop bit.
- Each bit is held for a fixed number of clock cycles.
- Used to generate stimulus and status streams toward other CPU-side logic and to exercise the line samplers on the board.

Parameters:
- DATA_W, 8, data bits per frame; legal range 1..32.
- CLKS_PER_BIT, 4, clock cycles each bit is held on tx_line; legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_W  word to send; sampled only on the accept edge.
- tx_valid  input  1  producer has a word; held high until accepted.
- tx_ready  output  1  transmitter can accept a word this cycle.
- tx_line  output  1  serial line, registered; idle level 0.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse in the last cycle of a frame's stop bit.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset values (rst high at a rising edge), effective the following cycle: state=IDLE, tx_line=0, busy=0, done=0, bit and cycle counters=0, shift register=0.
- tx_ready is combinational: (state==IDLE) && !rst.
- States are IDLE, START, DATA, STOP.
- IDLE: tx_line=0. Accept occurs at an edge where tx_valid && tx_ready. On accept: tx_data goes into the shift register, the cycle counter is cleared, and state becomes START.
- START: tx_line=1 for CLKS_PER_BIT cycles, then state becomes DATA with bit index 0.
- DATA: tx_line = shift register MSB for CLKS_PER_BIT cycles per bit. The register shifts left at each bit boundary. After DATA_W bits, state becomes STOP.
- STOP: tx_line=0 for CLKS_PER_BIT cycles. done=1 during the final STOP cycle only. State then becomes IDLE.
- Timing: tx_line is registered. The first start-bit cycle is the cycle immediately after the accept edge. A frame is exactly (DATA_W+2)*CLKS_PER_BIT cycles.
- busy=1 from the cycle after accept through the final STOP cycle inclusive. busy=0 in IDLE.
- Back-to-back frames: tx_ready rises in the first IDLE cycle after STOP. If tx_valid is high then, the next START begins one cycle later. Minimum inter-frame idle is therefore 1 cycle at line level 0.
- Handshake: tx_data and tx_valid are ignored while busy. Changes to tx_data mid-frame do not alter the frame in flight. Deasserting tx_valid before accept is a producer protocol error; no special handling is required.
- CLKS_PER_BIT=1: every bit lasts exactly one cycle. done coincides with the single STOP cycle.
- Counters: the cycle counter is $clog2(CLKS_PER_BIT)+1 bits wide and counts 0..CLKS_PER_BIT-1, then wraps to 0 at each bit boundary. The bit counter counts 0..DATA_W-1. Neither counter may overflow or wrap mid-bit.
- Reset mid-frame: the frame is abandoned. tx_line=0 and state=IDLE from the next cycle. No done pulse is issued. tx_ready=1 in the first cycle with rst low.
- rst and tx_valid high together: rst wins and no accept occurs. The word must be re-presented after reset.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4: send 0xA5 with tx_valid for one accept edge.
  - tx_line per 4-cycle bit must read 1 | 1,0,1,0,0,1,0,1 | 0, for 40 cycles total.
  - busy must be high for exactly 40 cycles.
  - done must be high only in cycle 40 after accept.
  - tx_ready must return high in cycle 41.
- Back-to-back: hold tx_valid high with 0xFF then 0x00 queued.
  - Frame 2 start bit must begin exactly 2 cycles after frame 1's done cycle, i.e. done cycle, 1 idle cycle, then the start bit.
  - Frame 2 data must be all zeros.
- CLKS_PER_BIT=1, send 0x81: tx_line must read 1,1,0,0,0,0,0,0,1,0 on 10 consecutive cycles, with done on cycle 10.
- Mid-frame data change: accept 0x3C, then drive tx_data=0xFF and pulse tx_valid during DATA. The transmitted bits must remain 0,0,1,1,1,1,0,0, and no second accept may occur until tx_ready=1.
- Reset mid-frame: assert rst for 1 cycle during data bit 3.
  - tx_line must be 0 and busy 0 on the next cycle.
  - No done pulse may occur.
  - A new send of 0x01 afterwards must produce a correct full frame.
- Reset/valid collision: rst=1 and tx_valid=1 on the same edge must give no accept and busy=0. After rst drops, the word must be accepted on the first edge.
